// File: rtl/uart_tx_unit_pkg.sv
// Shared definitions for the UART transmit unit: store address, FSM states
// and the per-slot enqueue decode.
package uart_tx_unit_pkg;

  localparam logic [31:0] UART_ADDR = 32'hF000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Only the lowest byte lane of a store carries UART data.
  function automatic logic uart_enq(input logic [31:0] addr, input logic [3:0] bm);
    return (addr == UART_ADDR) && bm[0];
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with two ordered write ports and one read port; reports
// occupancy and a one-cycle pulse for every edge on which a byte is dropped.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr0_en,
  input  logic [7:0]               i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [7:0]               i_wr1_data,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic [CW-1:0] w_free;
  logic          w_acc0;
  logic          w_acc1;
  logic [AW-1:0] w_wr1_ptr;

  assign w_pop  = i_rd_en && (r_count != '0);
  // A same-edge pop frees its slot for this edge's pushes.
  assign w_free = CW'(DEPTH) - r_count + CW'(w_pop);
  assign w_acc0 = i_wr0_en && (w_free != '0);
  assign w_acc1 = i_wr1_en && (w_free > CW'(w_acc0));
  assign w_wr1_ptr = r_wr_ptr + AW'(w_acc0);

  always_ff @(posedge i_clk) begin
    if (w_acc0) r_mem[r_wr_ptr]  <= i_wr0_data;
    if (w_acc1) r_mem[w_wr1_ptr] <= i_wr1_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_acc0) + AW'(w_acc1);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = (i_wr0_en && !w_acc0) || (i_wr1_en && !w_acc1);

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter fed by byte stores from both issue slots: enqueue decode,
// baud timing and the 8N1 framing FSM around a dual-write byte FIFO.
module uart_tx_unit
  import uart_tx_unit_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  write_en_bmEX1,
  input  logic [3:0]  write_en_bmEX2,
  input  logic [31:0] write_addressEX1,
  input  logic [31:0] write_addressEX2,
  input  logic [31:0] storevalue_wordEX1,
  input  logic [31:0] storevalue_wordEX2,
  output logic        uart_tx,
  output logic        uart_stall,
  output logic        tx_busy,
  output logic        uart_overflow
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CPB - 1);

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          r_ovf;

  logic          w_req1;
  logic          w_req2;
  logic          w_pop;
  logic [7:0]    w_fifo_data;
  logic [CW-1:0] w_fifo_count;
  logic          w_ovf_pulse;
  logic          w_has_data;
  logic          w_baud_done;
  logic          w_unused;

  assign w_req1 = uart_enq(write_addressEX1, write_en_bmEX1);
  assign w_req2 = uart_enq(write_addressEX2, write_en_bmEX2);
  assign w_unused = &{1'b0, write_en_bmEX1[3:1], write_en_bmEX2[3:1],
                      storevalue_wordEX1[31:8], storevalue_wordEX2[31:8]};

  uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_wr0_en   (w_req1),
    .i_wr0_data (storevalue_wordEX1[7:0]),
    .i_wr1_en   (w_req2),
    .i_wr1_data (storevalue_wordEX2[7:0]),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_fifo_data),
    .o_count    (w_fifo_count),
    .o_overflow (w_ovf_pulse)
  );

  assign w_has_data  = (w_fifo_count != '0);
  assign w_baud_done = (r_baud == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_ovf   <= r_ovf | w_ovf_pulse;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = BAUD_RELOAD;
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_baud_nxt  = BAUD_RELOAD;
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = BAUD_RELOAD;
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            // The current bit always sits in shift[0]; shift[1] is next.
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_done) begin
          if (w_has_data) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
            w_baud_nxt  = BAUD_RELOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign uart_tx       = r_tx;
  assign tx_busy       = (r_state != ST_IDLE);
  assign uart_overflow = r_ovf;
  assign uart_stall    = (CW'(FIFO_DEPTH) - w_fifo_count) < CW'(2);

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: two instances (depth 4 and depth 16) at
// 4 clocks per bit, with a serial receiver checking frames against a scoreboard.
module tb_uart_tx_unit;
  import uart_tx_unit_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  bm1_a = '0, bm2_a = '0, bm1_b = '0, bm2_b = '0;
  logic [31:0] ad1_a = '0, ad2_a = '0, ad1_b = '0, ad2_b = '0;
  logic [31:0] d1_a = '0, d2_a = '0, d1_b = '0, d2_b = '0;
  logic        tx_a, stall_a, busy_a, ovf_a;
  logic        tx_b, stall_b, busy_b, ovf_b;

  uart_tx_unit #(.CLK_HZ(4), .BAUD(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .write_en_bmEX1(bm1_a), .write_en_bmEX2(bm2_a),
    .write_addressEX1(ad1_a), .write_addressEX2(ad2_a),
    .storevalue_wordEX1(d1_a), .storevalue_wordEX2(d2_a),
    .uart_tx(tx_a), .uart_stall(stall_a), .tx_busy(busy_a), .uart_overflow(ovf_a)
  );

  uart_tx_unit #(.CLK_HZ(4), .BAUD(1), .FIFO_DEPTH(16)) u_dut_b (
    .clk(clk), .rst(rst),
    .write_en_bmEX1(bm1_b), .write_en_bmEX2(bm2_b),
    .write_addressEX1(ad1_b), .write_addressEX2(ad2_b),
    .storevalue_wordEX1(d1_b), .storevalue_wordEX2(d2_b),
    .uart_tx(tx_b), .uart_stall(stall_b), .tx_busy(busy_b), .uart_overflow(ovf_b)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  int rx_cnt[2] = '{0, 0};
  bit mon_act[2] = '{0, 0};
  int mon_cyc[2] = '{0, 0};
  logic [7:0] mon_sh[2] = '{8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int d, input logic [7:0] b);
    if (d == 0) sb_a.push_back(b);
    else        sb_b.push_back(b);
  endtask

  // Caller is positioned just after a falling edge; inputs persist for one rising edge.
  task automatic drive(input int d, input logic [3:0] m1, input logic [31:0] a1, input logic [7:0] b1,
                       input logic [3:0] m2, input logic [31:0] a2, input logic [7:0] b2);
    if (d == 0) begin
      bm1_a = m1; ad1_a = a1; d1_a = {24'hDEADBE, b1};
      bm2_a = m2; ad2_a = a2; d2_a = {24'hC0FFEE, b2};
    end else begin
      bm1_b = m1; ad1_b = a1; d1_b = {24'hDEADBE, b1};
      bm2_b = m2; ad2_b = a2; d2_b = {24'hC0FFEE, b2};
    end
    @(posedge clk);
    #1;
    bm1_a = '0; bm2_a = '0; ad1_a = '0; ad2_a = '0; d1_a = '0; d2_a = '0;
    bm1_b = '0; bm2_b = '0; ad1_b = '0; ad2_b = '0; d1_b = '0; d2_b = '0;
  endtask

  task automatic push1(input int d, input logic [7:0] b);
    drive(d, 4'b0001, UART_ADDR, b, 4'b0000, 32'h0, 8'h00);
    sb_push(d, b);
  endtask

  task automatic push2(input int d, input logic [7:0] b1, input logic [7:0] b2);
    drive(d, 4'b0001, UART_ADDR, b1, 4'b0001, UART_ADDR, b2);
    sb_push(d, b1);
    sb_push(d, b2);
  endtask

  // Length of the next contiguous tx_busy run; also the line value on the first sample.
  task automatic busy_run(input int d, output int run, output logic first_tx);
    logic b;
    run = 0;
    first_tx = 1'bx;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      b = (d == 0) ? busy_a : busy_b;
      if (i == 0) first_tx = (d == 0) ? tx_a : tx_b;
      if (b) run++;
      else if (run > 0) break;
    end
  endtask

  task automatic drain(input int d, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (d == 0 && sb_a.size() == 0 && !busy_a) break;
      if (d == 1 && sb_b.size() == 0 && !busy_b) break;
    end
    chk(tag, i < budget, 1);
  endtask

  // Serial receiver: samples each bit mid-cell on falling edges, aborts on reset.
  initial begin
    logic l;
    int exp_avail;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        l = (d == 0) ? tx_a : tx_b;
        if (rst !== 1'b1) mon_act[d] = 0;
        else if (!mon_act[d]) begin
          if (l === 1'b0) begin
            mon_act[d] = 1;
            mon_cyc[d] = 0;
          end
        end else mon_cyc[d]++;
        if (mon_act[d]) begin
          if (mon_cyc[d] == CPB / 2) chk("start_bit", l, 0);
          else if (mon_cyc[d] >= 6 && mon_cyc[d] <= 34 && ((mon_cyc[d] - 6) % CPB) == 0)
            mon_sh[d] = {l, mon_sh[d][7:1]};
          else if (mon_cyc[d] == 38) begin
            chk("stop_bit", l, 1);
            rx_cnt[d]++;
            exp_avail = (d == 0) ? sb_a.size() : sb_b.size();
            chk("frame_expected", exp_avail != 0, 1);
            if (exp_avail != 0) begin
              if (d == 0) chk("rx_byte_a", mon_sh[d], sb_a.pop_front());
              else        chk("rx_byte_b", mon_sh[d], sb_b.pop_front());
            end
          end
          if (mon_cyc[d] == 10 * CPB - 1) mon_act[d] = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    logic ft;
    int base;
    int i;
    bit seen;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);      chk("rst_tx_b", tx_b, 1);
    chk("rst_stall_a", stall_a, 0); chk("rst_stall_b", stall_b, 0);
    chk("rst_busy_a", busy_a, 0);  chk("rst_busy_b", busy_b, 0);
    chk("rst_ovf_a", ovf_a, 0);    chk("rst_ovf_b", ovf_b, 0);
    chk("rst_count_a", u_dut_a.u_fifo.r_count, 0);
    #2 rst = 1'b1;

    // Single byte 0xA5
    @(negedge clk);
    push1(0, 8'hA5);
    @(negedge clk);
    chk("t1_pre_tx", tx_a, 1);
    chk("t1_pre_busy", busy_a, 0);
    busy_run(0, run, ft);
    chk("t1_start_latency", ft, 0);
    chk("t1_busy_len", run, 40);
    chk("t1_rx_cnt", rx_cnt[0], 1);
    chk("t1_sb_empty", sb_a.size(), 0);

    // Dual issue, back-to-back frames
    base = rx_cnt[0];
    @(negedge clk);
    push2(0, 8'h41, 8'h42);
    busy_run(0, run, ft);
    chk("t2_busy_len", run, 80);
    chk("t2_rx_cnt", rx_cnt[0] - base, 2);
    chk("t2_sb_empty", sb_a.size(), 0);

    // Non-UART address and masked-out lane
    base = rx_cnt[0];
    @(negedge clk);
    drive(0, 4'b1111, 32'h0000_0100, 8'h55, 4'b1110, UART_ADDR, 8'h66);
    @(negedge clk);
    drive(0, 4'b0010, UART_ADDR, 8'h77, 4'b0001, 32'h0000_0100, 8'h88);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy_a || !tx_a) seen = 1;
    end
    chk("t3_count", u_dut_a.u_fifo.r_count, 0);
    chk("t3_no_activity", seen, 0);
    chk("t3_rx_cnt", rx_cnt[0] - base, 0);

    // Fill depth-4 FIFO, then force a dual push into one free slot
    base = rx_cnt[0];
    @(negedge clk);
    push1(0, 8'hB0);
    repeat (2) @(negedge clk);
    push1(0, 8'hB1);
    @(negedge clk);
    chk("t4_stall_cnt1", stall_a, 0);
    push1(0, 8'hB2);
    @(negedge clk);
    chk("t4_stall_cnt2", stall_a, 0);
    push1(0, 8'hB3);
    @(negedge clk);
    chk("t4_stall_cnt3", stall_a, 1);
    chk("t4_ovf_before", ovf_a, 0);
    drive(0, 4'b0001, UART_ADDR, 8'hC1, 4'b0001, UART_ADDR, 8'hC2);
    sb_push(0, 8'hC1);
    @(negedge clk);
    chk("t4_ovf_set", ovf_a, 1);
    chk("t4_stall_full", stall_a, 1);
    drain(0, 600, "t4_drain");
    chk("t4_rx_cnt", rx_cnt[0] - base, 5);
    chk("t4_ovf_sticky", ovf_a, 1);

    // Reset during data bit 3, with a second byte still queued
    base = rx_cnt[0];
    @(negedge clk);
    drive(0, 4'b0001, UART_ADDR, 8'h5A, 4'b0001, UART_ADDR, 8'h77);
    repeat (18) @(negedge clk);
    chk("t5_in_frame", busy_a, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_tx", tx_a, 1);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_ovf", ovf_a, 0);
    chk("t5_rst_count", u_dut_a.u_fifo.r_count, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (busy_a || !tx_a) seen = 1;
    end
    chk("t5_no_frames", seen, 0);
    chk("t5_rx_cnt", rx_cnt[0] - base, 0);

    // Stream 20 bytes through the depth-16 instance, honouring stall
    base = rx_cnt[1];
    for (int p = 0; p < 10; p++) begin
      for (i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (!stall_b) break;
      end
      chk("t6_stall_wait", i < 2000, 1);
      push2(1, 8'(2 * p), 8'(2 * p + 1));
    end
    drain(1, 1500, "t6_drain");
    chk("t6_rx_cnt", rx_cnt[1] - base, 20);
    chk("t6_ovf", ovf_b, 0);
    chk("t6_sb_empty", sb_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
